// File: rtl/acc_pkg.sv
// Shared encodings for the paired accumulator: half-register selects, load
// source select, and the shift-sequencer state type.
package acc_pkg;

    localparam logic [1:0] ACC_IDLE = 2'b00;
    localparam logic [1:0] ACC_SHR  = 2'b01;
    localparam logic [1:0] ACC_SHL  = 2'b10;
    localparam logic [1:0] ACC_LOAD = 2'b11;

    localparam logic ACC_SRC_ALU = 1'b0;
    localparam logic ACC_SRC_BUS = 1'b1;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'b00,
        SEQ_RUN  = 2'b01,
        SEQ_DONE = 2'b10
    } acc_state_e;

endpackage

// File: rtl/acc_pair_seq_if.sv
// Control/data bundle between the CPU datapath (master) and acc_pair_seq (slave).
// Handshake: seq_start is a one-cycle request sampled only while seq_busy=0;
// seq_busy stays high until the cycle after the single-cycle seq_done pulse.
interface acc_pair_seq_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(2*WIDTH+1)
);
    import acc_pkg::*;

    logic             acc_high_clr;
    logic             fill_value;
    logic             acc_in_select;
    logic [1:0]       acc_high_select;
    logic [1:0]       acc_low_select;
    logic [WIDTH-1:0] bus_data;
    logic [WIDTH-1:0] alu_data;
    logic             seq_start;
    logic             seq_dir;
    logic [CNT_W-1:0] seq_count;
    logic             seq_mul;

    logic [WIDTH-1:0] acc_high_data2alu;
    logic [WIDTH-1:0] acc_low_data2alu;
    logic             shift_out;
    logic             seq_busy;
    logic             seq_done;
    acc_state_e       seq_state;

    modport master (
        output acc_high_clr, fill_value, acc_in_select, acc_high_select,
               acc_low_select, bus_data, alu_data, seq_start, seq_dir,
               seq_count, seq_mul,
        input  acc_high_data2alu, acc_low_data2alu, shift_out, seq_busy,
               seq_done, seq_state
    );

    modport slave (
        input  acc_high_clr, fill_value, acc_in_select, acc_high_select,
               acc_low_select, bus_data, alu_data, seq_start, seq_dir,
               seq_count, seq_mul,
        output acc_high_data2alu, acc_low_data2alu, shift_out, seq_busy,
               seq_done, seq_state
    );

endinterface

// File: rtl/acc_half.sv
// One WIDTH-bit accumulator half: clear/load/shift/hold with serial ends so
// two halves can be chained into a single 2*WIDTH shifter.
module acc_half
    import acc_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ser_in_msb,
    input  logic             ser_in_lsb,
    output logic [WIDTH-1:0] q,
    output logic             ser_out_lsb,
    output logic             ser_out_msb
);

    logic [WIDTH-1:0] q_d, q_q;

    // Clear wins over every other operation.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else begin
            case (op)
                ACC_SHR:  q_d = {ser_in_msb, q_q[WIDTH-1:1]};
                ACC_SHL:  q_d = {q_q[WIDTH-2:0], ser_in_lsb};
                ACC_LOAD: q_d = load_val;
                default:  q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q           = q_q;
    assign ser_out_lsb = q_q[0];
    assign ser_out_msb = q_q[WIDTH-1];

endmodule

// File: rtl/acc_pair_seq.sv
// Double-width accumulator with manual per-half selects and a multi-cycle shift
// sequencer. Define ACC_MUL_STEP_EN to enable the shift-add multiply step mode.
module acc_pair_seq
    import acc_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(2*WIDTH+1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rd_en,
    acc_pair_seq_if.slave    bus,
    output wire  [WIDTH-1:0] high_data2bus,
    output wire  [WIDTH-1:0] low_data2bus
);

    logic [WIDTH-1:0] high_val, low_val;
    logic             h_lsb, h_msb, l_lsb, l_msb;
    logic [WIDTH-1:0] in_mux, h_eff;
    logic             h_eff_lsb, h_eff_msb;
    logic [WIDTH:0]   mul_sum;

    logic [1:0]       h_op, l_op;
    logic [WIDTH-1:0] h_load;
    logic             h_sin_msb, h_sin_lsb, l_sin_msb, l_sin_lsb;

    acc_state_e       state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             dir_d, dir_q;
    logic             fill_d, fill_q;
    logic             mul_d, mul_q;
    logic             busy_d, busy_q;
    logic             done_d, done_q;
    logic             shift_out_d, shift_out_q;

    assign in_mux = (bus.acc_in_select == ACC_SRC_BUS) ? bus.bus_data : bus.alu_data;

    // A cleared high half presents zero to the low half's chain input.
    assign h_eff     = bus.acc_high_clr ? '0 : high_val;
    assign h_eff_lsb = bus.acc_high_clr ? 1'b0 : h_lsb;
    assign h_eff_msb = bus.acc_high_clr ? 1'b0 : h_msb;
    assign mul_sum   = {1'b0, h_eff} + (l_lsb ? {1'b0, bus.alu_data} : '0);

    always_comb begin
        h_op        = ACC_IDLE;
        l_op        = ACC_IDLE;
        h_load      = in_mux;
        h_sin_msb   = bus.fill_value;
        h_sin_lsb   = bus.fill_value;
        l_sin_msb   = bus.fill_value;
        l_sin_lsb   = bus.fill_value;
        shift_out_d = shift_out_q;
        case (state_q)
            SEQ_IDLE: begin
                h_op = bus.acc_high_select;
                l_op = bus.acc_low_select;
                if (h_op == ACC_SHR && l_op == ACC_SHR) begin
                    l_sin_msb   = h_eff_lsb;
                    shift_out_d = l_lsb;
                end else if (h_op == ACC_SHL && l_op == ACC_SHL) begin
                    h_sin_lsb   = l_msb;
                    shift_out_d = h_eff_msb;
                end
            end
            SEQ_RUN: begin
                if (mul_q) begin
                    // {c, H} = H (+ addend), then {c, H, L} >> 1.
                    h_op        = ACC_LOAD;
                    h_load      = mul_sum[WIDTH:1];
                    l_op        = ACC_SHR;
                    l_sin_msb   = mul_sum[0];
                    shift_out_d = l_lsb;
                end else if (dir_q) begin
                    h_op        = ACC_SHL;
                    l_op        = ACC_SHL;
                    h_sin_lsb   = l_msb;
                    l_sin_lsb   = fill_q;
                    shift_out_d = h_eff_msb;
                end else begin
                    h_op        = ACC_SHR;
                    l_op        = ACC_SHR;
                    h_sin_msb   = fill_q;
                    l_sin_msb   = h_eff_lsb;
                    shift_out_d = l_lsb;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        fill_d  = fill_q;
        mul_d   = mul_q;
        case (state_q)
            SEQ_IDLE: begin
                if (bus.seq_start) begin
                    dir_d   = bus.seq_dir;
                    fill_d  = bus.fill_value;
`ifdef ACC_MUL_STEP_EN
                    mul_d   = bus.seq_mul;
`else
                    mul_d   = 1'b0;
`endif
                    cnt_d   = bus.seq_count;
                    state_d = (bus.seq_count == '0) ? SEQ_DONE : SEQ_RUN;
                end
            end
            SEQ_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = SEQ_DONE;
                end
            end
            SEQ_DONE: state_d = SEQ_IDLE;
            default:  state_d = SEQ_IDLE;
        endcase
        busy_d = (state_d != SEQ_IDLE);
        done_d = (state_d == SEQ_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= SEQ_IDLE;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            fill_q      <= 1'b0;
            mul_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            shift_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            fill_q      <= fill_d;
            mul_q       <= mul_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            shift_out_q <= shift_out_d;
        end
    end

`ifndef ACC_MUL_STEP_EN
    logic unused_seq_mul;
    assign unused_seq_mul = bus.seq_mul;
`endif

    acc_half #(.WIDTH(WIDTH)) u_high (
        .clk         (clk),
        .rst_n       (reset_n),
        .clr         (bus.acc_high_clr),
        .op          (h_op),
        .load_val    (h_load),
        .ser_in_msb  (h_sin_msb),
        .ser_in_lsb  (h_sin_lsb),
        .q           (high_val),
        .ser_out_lsb (h_lsb),
        .ser_out_msb (h_msb)
    );

    acc_half #(.WIDTH(WIDTH)) u_low (
        .clk         (clk),
        .rst_n       (reset_n),
        .clr         (1'b0),
        .op          (l_op),
        .load_val    (in_mux),
        .ser_in_msb  (l_sin_msb),
        .ser_in_lsb  (l_sin_lsb),
        .q           (low_val),
        .ser_out_lsb (l_lsb),
        .ser_out_msb (l_msb)
    );

    assign bus.acc_high_data2alu = high_val;
    assign bus.acc_low_data2alu  = low_val;
    assign bus.shift_out         = shift_out_q;
    assign bus.seq_busy          = busy_q;
    assign bus.seq_done          = done_q;
    assign bus.seq_state         = state_q;

    assign high_data2bus = rd_en ? high_val : 'z;
    assign low_data2bus  = rd_en ? low_val  : 'z;

endmodule

// File: tb/tb_acc_pair_seq.sv
// Directed bench for acc_pair_seq (WIDTH=4); multiply expectations follow ACC_MUL_STEP_EN.
module tb_acc_pair_seq;
    import acc_pkg::*;

    localparam int W  = 4;
    localparam int CW = $clog2(2*W+1);

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic rd_en   = 1'b0;
    tri1 [W-1:0] high_bus;
    tri1 [W-1:0] low_bus;

    int n_total = 0;
    int n_bad   = 0;
    int busy_n, done_n, pulses;
    bit timed_out;

    acc_pair_seq_if #(.WIDTH(W)) bus_if ();

    acc_pair_seq #(.WIDTH(W)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .rd_en         (rd_en),
        .bus           (bus_if),
        .high_data2bus (high_bus),
        .low_data2bus  (low_bus)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_inputs();
        bus_if.acc_high_clr    = 1'b0;
        bus_if.fill_value      = 1'b0;
        bus_if.acc_in_select   = ACC_SRC_ALU;
        bus_if.acc_high_select = ACC_IDLE;
        bus_if.acc_low_select  = ACC_IDLE;
        bus_if.bus_data        = '0;
        bus_if.seq_start       = 1'b0;
        bus_if.seq_dir         = 1'b0;
        bus_if.seq_count       = '0;
        bus_if.seq_mul         = 1'b0;
    endtask

    task automatic load_half(input bit high, input logic src, input logic [W-1:0] val);
        bus_if.acc_in_select = src;
        if (src == ACC_SRC_BUS) bus_if.bus_data = val;
        else                    bus_if.alu_data = val;
        if (high) bus_if.acc_high_select = ACC_LOAD;
        else      bus_if.acc_low_select  = ACC_LOAD;
        tick(1);
        bus_if.acc_high_select = ACC_IDLE;
        bus_if.acc_low_select  = ACC_IDLE;
    endtask

    // Starts a sequence and samples until busy drops, scrambling manual inputs if asked.
    task automatic run_seq(input logic dir, input logic fill, input logic mul,
                           input logic [CW-1:0] cnt, input bit scramble,
                           output int busy_cnt, output int done_cnt, output bit to);
        busy_cnt = 0;
        done_cnt = 0;
        to       = 1'b1;
        bus_if.seq_dir    = dir;
        bus_if.fill_value = fill;
        bus_if.seq_mul    = mul;
        bus_if.seq_count  = cnt;
        bus_if.seq_start  = 1'b1;
        tick(1);
        bus_if.seq_start = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus_if.seq_busy) busy_cnt++;
            if (bus_if.seq_done) done_cnt++;
            if (!bus_if.seq_busy) begin
                to = 1'b0;
                break;
            end
            if (scramble) begin
                bus_if.acc_high_select = 2'($urandom_range(0, 3));
                bus_if.acc_low_select  = 2'($urandom_range(0, 3));
                bus_if.acc_in_select   = 1'($urandom_range(0, 1));
                bus_if.bus_data        = W'($urandom_range(0, 15));
                bus_if.fill_value      = 1'($urandom_range(0, 1));
                bus_if.seq_start       = 1'($urandom_range(0, 1));
            end
            tick(1);
        end
        idle_inputs();
    endtask

    initial begin
        bus_if.alu_data = '0;
        idle_inputs();
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(1);
        chk("rst_high", bus_if.acc_high_data2alu, 4'h0);
        chk("rst_low",  bus_if.acc_low_data2alu,  4'h0);
        chk("rst_sout", bus_if.shift_out, 1'b0);
        chk("rst_busy", bus_if.seq_busy,  1'b0);
        chk("rst_done", bus_if.seq_done,  1'b0);

        load_half(1'b1, ACC_SRC_ALU, 4'b0101);
        chk("ld_high", bus_if.acc_high_data2alu, 4'b0101);
        chk("ld_low",  bus_if.acc_low_data2alu,  4'b0000);
        rd_en = 1'b1;
        #1;
        chk("bus_high_on", high_bus, 4'b0101);
        chk("bus_low_on",  low_bus,  4'b0000);
        rd_en = 1'b0;
        #1;
        chk("bus_high_off", high_bus, 4'b1111);
        chk("bus_low_off",  low_bus,  4'b1111);

        load_half(1'b0, ACC_SRC_BUS, 4'b0010);
        chk("ld_low_bus", bus_if.acc_low_data2alu, 4'b0010);
        bus_if.fill_value      = 1'b0;
        bus_if.acc_high_select = ACC_SHR;
        bus_if.acc_low_select  = ACC_SHR;
        tick(1);
        idle_inputs();
        chk("shr_high", bus_if.acc_high_data2alu, 4'b0010);
        chk("shr_low",  bus_if.acc_low_data2alu,  4'b1001);
        chk("shr_sout", bus_if.shift_out, 1'b0);

        run_seq(1'b1, 1'b1, 1'b0, CW'(3), 1'b1, busy_n, done_n, timed_out);
        chk("shl3_to",   timed_out, 1'b0);
        chk("shl3_busy", busy_n, 4);
        chk("shl3_done", done_n, 1);
        chk("shl3_high", bus_if.acc_high_data2alu, 4'b0100);
        chk("shl3_low",  bus_if.acc_low_data2alu,  4'b1111);
        chk("shl3_sout", bus_if.shift_out, 1'b1);
        chk("shl3_idle", bus_if.seq_state, SEQ_IDLE);

        // Opposite directions: independent halves, shift_out holds.
        bus_if.fill_value      = 1'b0;
        bus_if.acc_high_select = ACC_SHL;
        bus_if.acc_low_select  = ACC_SHR;
        tick(1);
        idle_inputs();
        chk("split_high", bus_if.acc_high_data2alu, 4'b1000);
        chk("split_low",  bus_if.acc_low_data2alu,  4'b0111);
        chk("split_sout", bus_if.shift_out, 1'b1);

        bus_if.seq_count = CW'(5);
        bus_if.seq_start = 1'b1;
        tick(1);
        bus_if.seq_start = 1'b0;
        tick(1);
        chk("mid_busy", bus_if.seq_busy, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("arst_high", bus_if.acc_high_data2alu, 4'h0);
        chk("arst_low",  bus_if.acc_low_data2alu,  4'h0);
        chk("arst_sout", bus_if.shift_out, 1'b0);
        chk("arst_busy", bus_if.seq_busy, 1'b0);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            if (bus_if.seq_done) pulses++;
            tick(1);
            if (i == 1) reset_n = 1'b1;
        end
        chk("arst_nodone", pulses, 0);
        run_seq(1'b1, 1'b1, 1'b0, CW'(2), 1'b0, busy_n, done_n, timed_out);
        chk("post_to",   timed_out, 1'b0);
        chk("post_busy", busy_n, 3);
        chk("post_done", done_n, 1);
        chk("post_high", bus_if.acc_high_data2alu, 4'b0000);
        chk("post_low",  bus_if.acc_low_data2alu,  4'b0011);
        chk("post_sout", bus_if.shift_out, 1'b0);

        load_half(1'b1, ACC_SRC_ALU, 4'b1010);
        bus_if.acc_high_clr    = 1'b1;
        bus_if.acc_in_select   = ACC_SRC_BUS;
        bus_if.bus_data        = 4'b0011;
        bus_if.acc_high_select = ACC_LOAD;
        bus_if.acc_low_select  = ACC_LOAD;
        tick(1);
        idle_inputs();
        chk("clr_high", bus_if.acc_high_data2alu, 4'b0000);
        chk("clr_low",  bus_if.acc_low_data2alu,  4'b0011);

        run_seq(1'b0, 1'b1, 1'b0, CW'(0), 1'b0, busy_n, done_n, timed_out);
        chk("cnt0_to",   timed_out, 1'b0);
        chk("cnt0_busy", busy_n, 1);
        chk("cnt0_done", done_n, 1);
        chk("cnt0_high", bus_if.acc_high_data2alu, 4'b0000);
        chk("cnt0_low",  bus_if.acc_low_data2alu,  4'b0011);

        load_half(1'b0, ACC_SRC_BUS, 4'b0110);
        bus_if.alu_data = 4'b0101;
        run_seq(1'b0, 1'b0, 1'b1, CW'(4), 1'b0, busy_n, done_n, timed_out);
        chk("mul_to",   timed_out, 1'b0);
        chk("mul_busy", busy_n, 5);
`ifdef ACC_MUL_STEP_EN
        chk("mul_high", bus_if.acc_high_data2alu, 4'b0001);
        chk("mul_low",  bus_if.acc_low_data2alu,  4'b1110);
`else
        chk("mul_high", bus_if.acc_high_data2alu, 4'b0000);
        chk("mul_low",  bus_if.acc_low_data2alu,  4'b0000);
`endif
        chk("mul_sout", bus_if.shift_out, 1'b0);

        load_half(1'b0, ACC_SRC_BUS, 4'b0100);
        run_seq(1'b0, 1'b1, 1'b0, CW'(9), 1'b0, busy_n, done_n, timed_out);
        chk("long_to",   timed_out, 1'b0);
        chk("long_busy", busy_n, 10);
        chk("long_done", done_n, 1);
        chk("long_high", bus_if.acc_high_data2alu, 4'b1111);
        chk("long_low",  bus_if.acc_low_data2alu,  4'b1111);
        chk("long_sout", bus_if.shift_out, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/acc_pair_seq.md
Name: acc_pair_seq

Overview:
- Parametrised successor to the 4-bit CPU accumulator.
- Double-width accumulator: two WIDTH-bit halves (high, low), each with an independent IDLE / SHIFT_RIGHT / SHIFT_LEFT / LOAD select.
- Loads from the ALU result or the data bus. When both halves shift the same way, they shift as one 2*WIDTH chain.
- Adds an autonomous multi-cycle shift sequencer (start/busy/done handshake) and a shift-out carry bit, for multi-bit shift instructions and shift-add multiply.

Parameters:
- WIDTH, 4, bits per half; legal range 2..32.
- CNT_W, $clog2(2*WIDTH+1), width of seq_count.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- acc_high_clr  in  1  synchronous clear of the high half, active-high.
- fill_value  in  1  bit shifted into a vacated end.
- rd_en  in  1  when 1, drive the *2bus outputs; when 0, they are 'z'.
- acc_in_select  in  1  0 = alu_data, 1 = bus_data.
- acc_high_select  in  2  00 IDLE, 01 SHR, 10 SHL, 11 LOAD.
- acc_low_select  in  2  same encoding as acc_high_select.
- bus_data  in  WIDTH  bus load source.
- alu_data  in  WIDTH  ALU load source; multiply addend.
- seq_start  in  1  one-cycle request to start a sequence.
- seq_dir  in  1  0 = right, 1 = left.
- seq_count  in  CNT_W  number of shift steps.
- seq_mul  in  1  multiply mode; ignored unless ACC_MUL_STEP_EN.
- high_data2bus  out  WIDTH  high half, tri-stated by rd_en.
- low_data2bus  out  WIDTH  low half, tri-stated by rd_en.
- acc_high_data2alu  out  WIDTH  high half, always driven.
- acc_low_data2alu  out  WIDTH  low half, always driven.
- shift_out  out  1  last bit shifted out of the chain.
- seq_busy  out  1  sequencer running.
- seq_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (reset_n=0, asynchronous): high, low, shift_out, seq_busy, seq_done, step counter = 0; FSM -> IDLE. A sequence in progress is abandoned and no done pulse is produced.
- All register updates occur on the rising clk edge. The *2alu outputs reflect the register with zero added latency.

Manual mode (FSM IDLE):
- LOAD: the selected half takes mux(acc_in_select).
- Both halves SHR: {fill, H, L} >> 1; shift_out = L[0].
- Both halves SHL: {H, L, fill} << 1; shift_out = H[MSB].
- A single half shifting (or the two halves in opposite directions): each shifting half is independent, fill_value enters its vacated end, and shift_out is unchanged.
- IDLE: hold.

acc_high_clr:
- Overrides every other high-half action, in any FSM state.
- The low half still performs its own action, seeing H=0 as its chain input.

FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on seq_start=1.
  - Latch seq_dir, fill_value, seq_mul and seq_count.
  - If seq_count=0, go directly to DONE with no shift.
- RUN: one concatenated 2*WIDTH shift per cycle in the latched direction with the latched fill.
  - The counter decrements each step; after the final step the FSM goes to DONE.
  - acc_*_select inputs are ignored and seq_start is ignored.
- DONE: seq_done=1 for exactly one cycle, then IDLE. seq_start in this cycle is ignored.
- seq_busy = 1 in RUN and DONE.
- Latency: seq_count=N gives N busy shift cycles, and seq_done in cycle N+1 after the start edge.
- seq_count > 2*WIDTH is legal: the chain fully fills with fill_value.

Optional Feature:
- ACC_MUL_STEP_EN defined:
  - A sequence started with seq_mul=1 runs the multiply step each cycle: if L[0], {c, H} = H + alu_data, else c = 0; then {c, H, L} >> 1.
  - The latched direction and fill are ignored.
  - With H=0, L=multiplier and seq_count=WIDTH, the unsigned product ends up in {H, L}.
- ACC_MUL_STEP_EN undefined: seq_mul is ignored and a normal shift sequence runs.
- The port exists in both builds.

Decomposition:
- Package acc_pkg holds:
  - the select encodings (ACC_IDLE, ACC_SHR, ACC_SHL, ACC_LOAD);
  - the source encodings (ACC_SRC_ALU=0, ACC_SRC_BUS=1);
  - the FSM state enum.
- One sub-module, acc_half: a WIDTH-bit register with load/shift/hold, and serial-in/serial-out ports for chaining, instantiated twice.
- The sequencer FSM lives in the top level.

Test Plan (WIDTH=4):
- Reset, then alu_data=0101, acc_high_select=LOAD for one cycle -> high=0101, low=0000. With rd_en=1, high_data2bus=0101; with rd_en=0, high_data2bus is 'z'.
- Load high=0101 from ALU and low=0010 from bus, then both SHR with fill=0 for one cycle -> high=0010, low=1001, shift_out=0.
- From high=0010, low=1001: seq_start, seq_dir=1, seq_count=3, fill=1 -> seq_busy high for 4 cycles. Final high=0100, low=1111, shift_out=1, one seq_done pulse; selects toggled during RUN have no effect.
- reset_n=0 two cycles into a seq_count=5 sequence -> all outputs 0 immediately, no seq_done pulse, and the next seq_start works normally.
- acc_high_clr=1 together with acc_high_select=LOAD and low=LOAD with bus=0011 -> high=0000, low=0011. seq_count=0 -> no shift, seq_done on the next cycle.
- ACC_MUL_STEP_EN build: high=0000, low=0110, alu_data=0101, seq_mul=1, seq_count=4 -> {high, low}=0001_1110 (30). The non-MUL build given the same stimulus performs a plain right shift (result 0000_0000 with fill=0).
